// File: rtl/bias_loader_pkg.sv
// -----------------------------------------------------------------------------
// bias_loader_pkg
// Shared definitions for the bias buffer feeder.
//   K_CHANNELS : bias words packed into one buffer row
//   ACC_WIDTH  : width of one bias word
//   ROW_W      : width of one packed row (lane i at [i*ACC_WIDTH +: ACC_WIDTH])
//   LANE_W     : width of the lane index counter
//   bias_ld_state_e : loader FSM states
// -----------------------------------------------------------------------------
package bias_loader_pkg;

   localparam int K_CHANNELS = 4;
   localparam int ACC_WIDTH  = 32;
   localparam int ROW_W      = K_CHANNELS * ACC_WIDTH;
   localparam int LANE_W     = (K_CHANNELS > 1) ? $clog2(K_CHANNELS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } bias_ld_state_e;

endpackage

// File: rtl/bias_loader.sv
// -----------------------------------------------------------------------------
// bias_loader
// Accepts a stream of bias words, packs K_CHANNELS consecutive words into one
// row and writes the rows into the bias buffer starting at a base address.
//
// Ports:
//   clk_i, rst_async_n_i       clock (rising edge), async active-low reset
//   start_i, abort_i           job start pulse (IDLE only) / synchronous abort
//   base_addr_i, num_rows_i    job configuration, sampled with start_i
//   s_valid_i/s_ready_o/s_data_i  input word stream
//   loader_wr_en_o/_addr_o/_data_o  row write port to the bias buffer
//   busy_o, done_o, cfg_err_o  status (done_o / cfg_err_o are 1-cycle pulses)
//   rows_written_o             rows fully written in the current/last job
//   state_o                    current FSM state (observation only)
//
// Handshake: a word transfers on a rising edge where s_valid_i and s_ready_o
// are both high; s_ready_o is registered and does not depend on s_valid_i.
// A held word (s_valid_i high, s_ready_o low) must stay stable until taken.
// -----------------------------------------------------------------------------
module bias_loader
   import bias_loader_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_async_n_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [CNT_W-1:0]      num_rows_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [ACC_WIDTH-1:0]  s_data_i,
   output logic                  loader_wr_en_o,
   output logic [ADDR_W-1:0]     loader_wr_addr_o,
   output logic [ROW_W-1:0]      loader_wr_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  cfg_err_o,
   output logic [CNT_W-1:0]      rows_written_o,
   output bias_ld_state_e        state_o
);

   localparam int                SPAN_W    = CNT_W + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(K_CHANNELS - 1);

   bias_ld_state_e      state_q, state_d;
   logic                s_ready_q;
   logic [LANE_W-1:0]   lane_cnt_q;
   logic [ACC_WIDTH-1:0] lane_q [K_CHANNELS];
   logic [ADDR_W-1:0]   base_q;
   logic [CNT_W-1:0]    num_rows_q;
   logic [CNT_W-1:0]    row_cnt_q;
   logic [CNT_W-1:0]    rows_written_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [ROW_W-1:0]    wr_data_q;
   logic                cfg_err_q;

   logic                start_idle;
   logic                zero_rows;
   logic                range_bad;
   logic [SPAN_W-1:0]   span;
   logic                hs;
   logic                lane_last;
   logic                row_last;
   logic [ROW_W-1:0]    row_next;

   assign start_idle = start_i && (state_q == IDLE);
   assign zero_rows  = (num_rows_i == '0);
   // Widened by one bit so base + rows cannot wrap back into range.
   assign span       = SPAN_W'(base_addr_i) + SPAN_W'(num_rows_i);
   assign range_bad  = (span > SPAN_W'(DEPTH));
   // Abort wins over any word offered in the same cycle.
   assign hs         = s_valid_i && s_ready_q && !abort_i;
   assign lane_last  = (lane_cnt_q == LAST_LANE);
   assign row_last   = ((row_cnt_q + CNT_W'(1)) == num_rows_q);

   // Row being completed: stored lanes plus the word arriving now in the top lane.
   always_comb begin
      row_next = '0;
      for (int i = 0; i < K_CHANNELS - 1; i++) begin
         row_next[i*ACC_WIDTH +: ACC_WIDTH] = lane_q[i];
      end
      row_next[(K_CHANNELS-1)*ACC_WIDTH +: ACC_WIDTH] = s_data_i;
   end

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (zero_rows)       state_d = DONE;
               else if (!range_bad) state_d = LOAD;
            end
         end
         LOAD: begin
            if (abort_i)                            state_d = IDLE;
            else if (hs && lane_last && row_last)   state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_o  = (state_q != IDLE);
      done_o  = (state_q == DONE) && !abort_i;
      state_o = state_q;
   end

   // Datapath: lane packing, row write port, counters
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         s_ready_q      <= 1'b0;
         lane_cnt_q     <= '0;
         for (int i = 0; i < K_CHANNELS; i++) lane_q[i] <= '0;
         base_q         <= '0;
         num_rows_q     <= '0;
         row_cnt_q      <= '0;
         rows_written_q <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         cfg_err_q      <= 1'b0;
      end else begin
         wr_en_q   <= hs && lane_last;
         cfg_err_q <= start_idle && !zero_rows && range_bad;

         if (start_idle && zero_rows) begin
            rows_written_q <= '0;
         end else if (start_idle && !range_bad) begin
            base_q         <= base_addr_i;
            num_rows_q     <= num_rows_i;
            lane_cnt_q     <= '0;
            row_cnt_q      <= '0;
            rows_written_q <= '0;
            s_ready_q      <= 1'b1;
         end

         if (abort_i && state_q != IDLE) begin
            // Partial row is dropped; a row already latched still strobes out.
            s_ready_q  <= 1'b0;
            lane_cnt_q <= '0;
         end else if (hs) begin
            lane_q[lane_cnt_q] <= s_data_i;
            if (lane_last) begin
               lane_cnt_q     <= '0;
               wr_data_q      <= row_next;
               wr_addr_q      <= base_q + ADDR_W'(row_cnt_q);
               row_cnt_q      <= row_cnt_q + CNT_W'(1);
               rows_written_q <= rows_written_q + CNT_W'(1);
               if (row_last) s_ready_q <= 1'b0;
            end else begin
               lane_cnt_q <= lane_cnt_q + LANE_W'(1);
            end
         end
      end
   end

   assign s_ready_o        = s_ready_q;
   assign loader_wr_en_o   = wr_en_q;
   assign loader_wr_addr_o = wr_addr_q;
   assign loader_wr_data_o = wr_data_q;
   assign cfg_err_o        = cfg_err_q;
   assign rows_written_o   = rows_written_q;

endmodule

// File: tb/tb_bias_loader.sv
// -----------------------------------------------------------------------------
// tb_bias_loader
// Directed bench for bias_loader. Expected row writes are queued when a job is
// set up; a monitor pops and compares on every write strobe.
// -----------------------------------------------------------------------------
module tb_bias_loader;
   import bias_loader_pkg::*;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 7;

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic                 abort;
   logic [ADDR_W-1:0]    base_addr;
   logic [CNT_W-1:0]     num_rows;
   logic                 s_valid;
   logic                 s_ready;
   logic [ACC_WIDTH-1:0] s_data;
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [ROW_W-1:0]     wr_data;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;
   logic [CNT_W-1:0]     rows_written;
   bias_ld_state_e       state;

   bias_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i            (clk),
      .rst_async_n_i    (rst_n),
      .start_i          (start),
      .abort_i          (abort),
      .base_addr_i      (base_addr),
      .num_rows_i       (num_rows),
      .s_valid_i        (s_valid),
      .s_ready_o        (s_ready),
      .s_data_i         (s_data),
      .loader_wr_en_o   (wr_en),
      .loader_wr_addr_o (wr_addr),
      .loader_wr_data_o (wr_data),
      .busy_o           (busy),
      .done_o           (done),
      .cfg_err_o        (cfg_err),
      .rows_written_o   (rows_written),
      .state_o          (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [ROW_W-1:0]  exp_q[$];
   int checks = 0;
   int passes = 0;

   int wr_count, done_count, cfg_err_count, busy_seen, ready_seen, hs_count, done_cyc;
   int wr_cyc[$];

   task automatic check(input string name, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic clear_counters();
      wr_count = 0; done_count = 0; cfg_err_count = 0; busy_seen = 0;
      ready_seen = 0; hs_count = 0; done_cyc = -1;
      wr_cyc.delete();
   endtask

   task automatic push_row(input logic [ADDR_W-1:0] addr, input logic [ACC_WIDTH-1:0] w0);
      logic [ACC_WIDTH-1:0] w1, w2, w3;
      w1 = w0 + 1; w2 = w0 + 2; w3 = w0 + 3;
      exp_addr_q.push_back(addr);
      exp_q.push_back({w3, w2, w1, w0});
   endtask

   // Monitor: every write strobe is matched against the expected queue.
   always @(negedge clk) begin
      if (wr_en) begin
         wr_count++;
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
         end else begin
            check("wr_addr", ROW_W'(wr_addr), ROW_W'(exp_addr_q.pop_front()));
            check("wr_data", wr_data, exp_q.pop_front());
         end
      end
      if (done)    begin done_count++; done_cyc = cyc; end
      if (cfg_err) cfg_err_count++;
      if (busy)    busy_seen++;
      if (s_ready) ready_seen++;
      if (s_ready && s_valid) hs_count++;
   end

   // ---------------- driver tasks ----------------
   task automatic start_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; num_rows = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offers one word and returns #1 after the edge that takes it.
   task automatic send_word(input logic [ACC_WIDTH-1:0] d, input bit rnd);
      int budget;
      if (rnd) begin
         repeat ($urandom_range(0, 3)) begin
            s_valid = 1'b0; s_data = $urandom;
            @(posedge clk); #1;
         end
      end
      s_valid = 1'b1; s_data = d;
      budget = 50;
      @(negedge clk);
      while (!s_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         checks++;
         $display("FAIL send_timeout: got s_ready 0 expected 1 for word %0h", d);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_words(input logic [ACC_WIDTH-1:0] first, input int n, input bit rnd);
      for (int i = 0; i < n; i++) send_word(first + ACC_WIDTH'(i), rnd);
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (done_count == 0 && n < max) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_count == 0) begin
         checks++;
         $display("FAIL done_timeout: got no done_o expected one within %0d cycles", max);
      end
   endtask

   task automatic basic_job(input string tag, input bit rnd);
      clear_counters();
      push_row(6'd5, 32'h1);
      push_row(6'd6, 32'h5);
      start_job(6'd5, 7'd2);
      send_words(32'h1, 8, rnd);
      wait_done(20);
      check({tag, "_wr_count"}, ROW_W'(wr_count), ROW_W'(2));
      check({tag, "_done_count"}, ROW_W'(done_count), ROW_W'(1));
      if (wr_cyc.size() == 2) begin
         if (!rnd) check({tag, "_row_gap"}, ROW_W'(wr_cyc[1] - wr_cyc[0]), ROW_W'(4));
         check({tag, "_done_with_last_wr"}, ROW_W'(done_cyc), ROW_W'(wr_cyc[1]));
      end
      check({tag, "_rows_written"}, ROW_W'(rows_written), ROW_W'(2));
      check({tag, "_ready_after"}, ROW_W'(s_ready), ROW_W'(0));
      @(negedge clk); #1;
      check({tag, "_busy_after"}, ROW_W'(busy), ROW_W'(0));
      check({tag, "_exp_empty"}, ROW_W'(exp_q.size()), ROW_W'(0));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; num_rows = '0;
      s_valid = 1'b0; s_data = '0;
      clear_counters();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ROW_W'(s_ready), ROW_W'(0));
      check("rst_wr_en", ROW_W'(wr_en), ROW_W'(0));
      check("rst_busy", ROW_W'(busy), ROW_W'(0));
      check("rst_rows_written", ROW_W'(rows_written), ROW_W'(0));
      check("rst_state", ROW_W'(state), ROW_W'(IDLE));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic job, valid always high
      basic_job("basic", 1'b0);

      // Same job with random stalls, then extra words that must not be taken
      basic_job("stall", 1'b1);
      s_valid = 1'b1; s_data = 32'hDEAD;
      repeat (5) @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("stall_hs_count", ROW_W'(hs_count), ROW_W'(8));

      // Range error, then the largest legal job ending at the last row
      clear_counters();
      start_job(6'd62, 7'd3);
      repeat (3) @(negedge clk);
      #1;
      check("range_cfg_err", ROW_W'(cfg_err_count), ROW_W'(1));
      check("range_busy", ROW_W'(busy_seen), ROW_W'(0));
      check("range_no_wr", ROW_W'(wr_count), ROW_W'(0));
      clear_counters();
      push_row(6'd61, 32'h101);
      push_row(6'd62, 32'h105);
      push_row(6'd63, 32'h109);
      start_job(6'd61, 7'd3);
      send_words(32'h101, 12, 1'b0);
      wait_done(20);
      check("edge_wr_count", ROW_W'(wr_count), ROW_W'(3));
      check("edge_cfg_err", ROW_W'(cfg_err_count), ROW_W'(0));
      check("edge_rows_written", ROW_W'(rows_written), ROW_W'(3));

      // Zero rows: done on the cycle after start, nothing else
      repeat (2) @(posedge clk);
      #1;
      clear_counters();
      start_job(6'd7, 7'd0);
      @(negedge clk); #1;
      check("zero_done", ROW_W'(done), ROW_W'(1));
      check("zero_busy", ROW_W'(busy), ROW_W'(1));
      check("zero_rows_written", ROW_W'(rows_written), ROW_W'(0));
      @(negedge clk); #1;
      check("zero_done_off", ROW_W'(done), ROW_W'(0));
      check("zero_ready_never", ROW_W'(ready_seen), ROW_W'(0));
      check("zero_no_wr", ROW_W'(wr_count), ROW_W'(0));

      // Abort after 6 words of a 4-row job
      clear_counters();
      push_row(6'd10, 32'h20);
      start_job(6'd10, 7'd4);
      send_words(32'h20, 6, 1'b0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("abort_wr_count", ROW_W'(wr_count), ROW_W'(1));
      check("abort_done", ROW_W'(done_count), ROW_W'(0));
      check("abort_rows_written", ROW_W'(rows_written), ROW_W'(1));
      check("abort_busy", ROW_W'(busy), ROW_W'(0));
      check("abort_ready", ROW_W'(s_ready), ROW_W'(0));
      // Next job must start from lane 0
      clear_counters();
      push_row(6'd20, 32'hA0);
      start_job(6'd20, 7'd1);
      send_words(32'hA0, 4, 1'b0);
      wait_done(20);
      check("post_abort_wr_count", ROW_W'(wr_count), ROW_W'(1));
      check("post_abort_rows_written", ROW_W'(rows_written), ROW_W'(1));

      // Reset between clock edges in the middle of a row
      repeat (2) @(posedge clk);
      #1;
      clear_counters();
      start_job(6'd0, 7'd2);
      send_words(32'h55, 3, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", ROW_W'(s_ready), ROW_W'(0));
      check("mid_rst_wr_en", ROW_W'(wr_en), ROW_W'(0));
      check("mid_rst_addr", ROW_W'(wr_addr), ROW_W'(0));
      check("mid_rst_data", wr_data, ROW_W'(0));
      check("mid_rst_busy", ROW_W'(busy), ROW_W'(0));
      check("mid_rst_done", ROW_W'(done), ROW_W'(0));
      check("mid_rst_cfg_err", ROW_W'(cfg_err), ROW_W'(0));
      check("mid_rst_rows_written", ROW_W'(rows_written), ROW_W'(0));
      repeat (3) @(negedge clk);
      #1;
      check("mid_rst_no_wr", ROW_W'(wr_count), ROW_W'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      basic_job("after_rst", 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test by 200000");
      $fatal(1, "watchdog");
   end

endmodule
